array_mac_accumulator: RTL
==========================

// Module: array_mac_accumulator
// PURPOSE
//   Registered multiply-accumulate stage built around eight_bit_array_multiplier.
//   Accepts a stream of 8-bit operand pairs via valid/ready and captures them into
//   operand registers. Each pair feeds one combinational array multiplier instance,
//   and the 16-bit product is registered. N_TERMS products are summed into one result,
//   which is presented on an output valid/ready port.
//   Sits downstream of the operand source and wraps/consumes the array multiplier's S.
// PARAMETERS
//   N_TERMS  8   products per accumulation; legal 1..255
//   ACC_W    19  accumulator width; legal >=16; 19 holds 8*255*255 without wrap
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair A/B valid
//   in_ready   out  1      block can take an operand pair
//   A          in   8      unsigned multiplicand
//   B          in   8      unsigned multiplier
//   out_valid  out  1      acc_out/overflow hold a completed result
//   out_ready  in   1      consumer takes the result
//   acc_out    out  ACC_W  sum of N_TERMS products, modulo 2^ACC_W
//   overflow   out  1      sticky: some add carried out of ACC_W in this result
//   busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; op_v, prod_v, in_cnt, acc_cnt, acc, overflow=0.
//     Also: in_ready=1, out_valid=0, acc_out=0, busy=0. Any partial accumulation is discarded.
//   Handshake: a pair is accepted on an edge where in_valid&in_ready.
//     On acceptance: A/B are written to op_r, op_v<=1, and in_cnt increments.
//     Otherwise op_v<=0.
//   Pipeline: the edge after acceptance writes prod_r<=S of mult(op_r), prod_v<=op_v.
//     The next edge performs acc<=acc+prod_r (zero-extended) if prod_v, and acc_cnt increments.
//   Latency: last pair accepted at edge E -> out_valid=1 visible after edge E+2.
//   FSM:
//     IDLE:  in_ready=1; the first acceptance moves to ACCUM.
//     ACCUM: in_ready=(in_cnt<N_TERMS).
//            At N_TERMS accepted, in_ready=0 and the pipeline drains.
//            Move to DONE on the edge where acc_cnt reaches N_TERMS (the last add).
//     DONE:  in_ready=0, out_valid=1; acc_out and overflow stay stable until taken.
//            out_valid&out_ready -> IDLE. That edge clears acc, overflow, in_cnt, acc_cnt.
//   No combinational path from in_valid to in_ready or from out_ready to out_valid.
//     in_ready is purely a function of the registered state and counters.
//   in_valid low mid-burst: bubbles enter the pipeline (prod_v=0, no add); no counters move.
//     Gaps of any length are legal.
//   Width: acc is modulo 2^ACC_W.
//     overflow<=1 on any add whose ACC_W+1-bit sum has its MSB set.
//     overflow stays set until the result handshake.
//   N_TERMS=1: a single acceptance goes IDLE->ACCUM.
//     in_ready drops immediately; DONE follows 2 edges later.
//   A or B = 0: the product is 0 and still counts as a term.
//   Back-to-back results: a new burst cannot start until DONE->IDLE.
//     The minimum gap is one IDLE cycle.
//   Reset mid-operation: immediate return to the reset values above.
//     No stale out_valid after rst_n deasserts.
// TESTING
//   1 Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, acc_out=0, overflow=0, busy=0.
//   2 N_TERMS=8, A=B=1..8 back-to-back, out_ready=1
//       -> acc_out=204, overflow=0, out_valid 2 cycles after the last accept.
//   3 N_TERMS=8, A=B=255 x8 with random in_valid gaps -> acc_out=520200, overflow=0.
//   4 ACC_W=16, N_TERMS=2, A=B=255 x2 -> acc_out=64514, overflow=1.
//       Next burst 1*1 x2 -> acc_out=2, overflow=0.
//   5 Backpressure: out_ready=0 for 10 cycles in DONE
//       -> acc_out stable, in_ready=0, extra in_valid ignored.
//       Release -> IDLE, next burst correct.
//   6 Assert rst_n=0 after 3 of 8 terms; deassert, send fresh 8x(2*3)
//       -> acc_out=48, no spurious out_valid.

Source files
------------

// File: rtl/array_mac_accumulator.sv
// Registered multiply-accumulate stage: operand pairs are multiplied by an
// unsigned 8x8 array multiplier and N_TERMS products are summed per result.

module eight_bit_array_multiplier (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] S
);
    wire [7:0] pp  [8];
    wire [8:0] row [8];
    wire [6:0] lsb;

    genvar i, j;

    for (i = 0; i < 8; i++) begin : g_pp
        assign pp[i] = A & {8{B[i]}};
    end

    assign row[0] = {1'b0, pp[0]};

    // row[i] holds bits i..i+8 of the running partial sum after adding pp[i]
    for (i = 1; i < 8; i++) begin : g_row
        wire [8:0] c;
        assign c[0] = 1'b0;
        for (j = 0; j < 8; j++) begin : g_fa
            wire x = pp[i][j];
            wire y = row[i-1][j+1];
            assign row[i][j] = x ^ y ^ c[j];
            assign c[j+1]    = (x & y) | (x & c[j]) | (y & c[j]);
        end
        assign row[i][8] = c[8];
    end

    for (i = 0; i < 7; i++) begin : g_lsb
        assign lsb[i] = row[i][0];
    end

    assign S = {row[7], lsb};
endmodule

// state  | meaning
// IDLE   | waiting for the first operand pair of a burst
// ACCUM  | taking pairs and draining the multiply/add pipeline
// DONE   | result held on acc_out/overflow until out_ready
module array_mac_accumulator #(
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned ACC_W   = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] N_LAST_M1 = CNT_W'(N_TERMS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             op_v;
    logic [15:0]      prod_r;
    logic             prod_v;
    logic [15:0]      mult_s;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] sum;
    logic             accept;

    eight_bit_array_multiplier u_mult (
        .A (op_a),
        .B (op_b),
        .S (mult_s)
    );

    // in_ready depends only on registered state so there is no in_valid->in_ready path
    assign in_ready  = (state == S_IDLE) || ((state == S_ACCUM) && (in_cnt < N_LAST));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign acc_out   = acc;
    assign sum       = {1'b0, acc} + SUM_W'(prod_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_v     <= 1'b0;
            prod_r   <= '0;
            prod_v   <= 1'b0;
            in_cnt   <= '0;
            acc_cnt  <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            op_v   <= accept;
            prod_v <= op_v;
            prod_r <= mult_s;
            if (accept) begin
                op_a   <= A;
                op_b   <= B;
                in_cnt <= in_cnt + 1'b1;
            end
            if (prod_v) begin
                acc     <= sum[ACC_W-1:0];
                acc_cnt <= acc_cnt + 1'b1;
                if (sum[ACC_W]) begin
                    overflow <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (prod_v && (acc_cnt == N_LAST_M1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // pipeline is empty here, so these clears cannot collide with an add
                    if (out_ready) begin
                        state    <= S_IDLE;
                        acc      <= '0;
                        overflow <= 1'b0;
                        in_cnt   <= '0;
                        acc_cnt  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
